// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: bus widths and FSM encoding.
package mem_arbiter_pkg;
   localparam int WORD_WIDTH = 16;
   localparam int MEM_DEPTH  = 2048;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters,
// with burst hold, a MAX_BURST fairness limit and a port-tagged 1-cycle read return.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH,
   parameter int MAX_BURST  = 8
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [WORD_WIDTH-1:0] addr0,
   input  logic [WORD_WIDTH-1:0] addr1,
   input  logic                  wr0,
   input  logic                  wr1,
   input  logic [WORD_WIDTH-1:0] wdata0,
   input  logic [WORD_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic [WORD_WIDTH-1:0] rdata,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [WORD_WIDTH-1:0] mem_addr,
   output logic                  mem_wr_en,
   output logic [WORD_WIDTH-1:0] mem_din,
   input  logic [WORD_WIDTH-1:0] mem_dout,
   output arb_state_t            dbg_state
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] burst_cnt, burst_cnt_nxt;
   logic          last, last_nxt;   // 1 = port 1 held the grant most recently
   logic          rd_pend, rd_port;
   logic          xfer0, xfer1, burst_at_max;

   assign xfer0        = req0 && (state == ARB_OWN0);
   assign xfer1        = req1 && (state == ARB_OWN1);
   assign burst_at_max = (burst_cnt == BURST_LAST);

   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      last_nxt      = last;
      case (state)
         ARB_IDLE: begin
            if (req0 && req1)  state_nxt = last ? ARB_OWN0 : ARB_OWN1;
            else if (req0)     state_nxt = ARB_OWN0;
            else if (req1)     state_nxt = ARB_OWN1;
         end
         ARB_OWN0: begin
            // Handover goes straight to the other port so no cycle is wasted.
            if (!req0 || (burst_at_max && req1)) begin
               last_nxt      = 1'b0;
               burst_cnt_nxt = '0;
               state_nxt     = req1 ? ARB_OWN1 : ARB_IDLE;
            end else if (!burst_at_max) begin
               burst_cnt_nxt = burst_cnt + CW'(1);
            end
         end
         ARB_OWN1: begin
            if (!req1 || (burst_at_max && req0)) begin
               last_nxt      = 1'b1;
               burst_cnt_nxt = '0;
               state_nxt     = req0 ? ARB_OWN0 : ARB_IDLE;
            end else if (!burst_at_max) begin
               burst_cnt_nxt = burst_cnt + CW'(1);
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state     <= ARB_IDLE;
         burst_cnt <= '0;
         last      <= 1'b1;
         rd_pend   <= 1'b0;
         rd_port   <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         last      <= last_nxt;
         // Return tag follows the issuing port, independent of any handover.
         rd_pend   <= (xfer0 && !wr0) || (xfer1 && !wr1);
         rd_port   <= xfer1;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_din   = '0;
      mem_wr_en = 1'b0;
      if (state == ARB_OWN0) begin
         mem_addr  = addr0;
         mem_din   = wdata0;
         mem_wr_en = xfer0 && wr0;
      end else if (state == ARB_OWN1) begin
         mem_addr  = addr1;
         mem_din   = wdata1;
         mem_wr_en = xfer1 && wr1;
      end
   end

   assign gnt0      = (state == ARB_OWN0);
   assign gnt1      = (state == ARB_OWN1);
   assign rvalid0   = rd_pend && !rd_port;
   assign rvalid1   = rd_pend && rd_port;
   assign rdata     = rd_pend ? mem_dout : '0;
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference of ownership, burst length and memory contents.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int W  = WORD_WIDTH;
   localparam int MB = 8;

   logic         clock = 1'b1;
   logic         nrst;
   logic         req0, req1, wr0, wr1;
   logic [W-1:0] addr0, addr1, wdata0, wdata1;
   logic         gnt0, gnt1, rvalid0, rvalid1, mem_wr_en;
   logic [W-1:0] rdata, mem_addr, mem_din, mem_dout;
   arb_state_t   dbg_state;

   always #5 clock = ~clock;

   mem_arbiter #(.WORD_WIDTH(W), .MAX_BURST(MB)) dut (
      .clock(clock), .nrst(nrst),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_din(mem_din),
      .mem_dout(mem_dout), .dbg_state(dbg_state)
   );

   // Byte-wide memory with registered read, zero-extended onto the bus.
   logic [7:0] mem [MEM_DEPTH];
   always @(posedge clock) begin
      if (mem_wr_en) mem[mem_addr[10:0]] <= mem_din[7:0];
      mem_dout <= {8'h00, mem[mem_addr[10:0]]};
   end

   // Reference state: owner -1 means nobody, runs counts accepted cycles of this grant.
   int           own, runs, last, cyc;
   int           ref_mem [MEM_DEPTH];
   logic [W-1:0] exp_q[$];
   bit           exp_known_q[$];
   int           exp_port_q[$];
   int           n_checks, n_fail;
   logic         obs_gnt0, obs_gnt1, obs_rvalid0, obs_rvalid1;
   logic [W-1:0] obs_rdata;
   int           run_port, run_len;
   int           run_q[$];

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      own = -1; runs = 0; last = 1;
      exp_q.delete(); exp_known_q.delete(); exp_port_q.delete();
   endtask

   // Called at posedge+1; drives one cycle, checks at negedge, advances the model.
   task automatic step(input bit r0, input bit w0, input logic [W-1:0] a0, input logic [W-1:0] d0,
                       input bit r1, input bit w1, input logic [W-1:0] a1, input logic [W-1:0] d1);
      bit acc, wr_sel, mine, other, pend;
      logic [W-1:0] a_sel, d_sel, pd;
      bit pk;
      int pp, cur;
      req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clock);
      obs_gnt0 = gnt0; obs_gnt1 = gnt1; obs_rvalid0 = rvalid0; obs_rvalid1 = rvalid1; obs_rdata = rdata;
      acc    = (own == 0 && r0) || (own == 1 && r1);
      wr_sel = (own == 0) ? w0 : w1;
      a_sel  = (own < 0) ? '0 : ((own == 0) ? a0 : a1);
      d_sel  = (own == 0) ? d0 : d1;
      check("gnt0", gnt0, own == 0);
      check("gnt1", gnt1, own == 1);
      check("state", dbg_state, (own < 0) ? ARB_IDLE : ((own == 0) ? ARB_OWN0 : ARB_OWN1));
      check("mem_wr_en", mem_wr_en, acc && wr_sel);
      check("mem_addr", mem_addr, a_sel);
      if (acc && wr_sel) check("mem_din", mem_din, d_sel);
      pend = (exp_q.size() > 0);
      pp = pend ? exp_port_q[0] : -1;
      check("rvalid0", rvalid0, pend && pp == 0);
      check("rvalid1", rvalid1, pend && pp == 1);
      check("gnt_onehot", gnt0 & gnt1, 1'b0);
      if (pend) begin
         pd = exp_q.pop_front(); pk = exp_known_q.pop_front(); void'(exp_port_q.pop_front());
         if (pk) check("rdata", rdata, pd);
      end
      cur = gnt0 ? 0 : (gnt1 ? 1 : -1);
      if (cur == run_port && cur >= 0) run_len++;
      else begin
         if (run_port >= 0) run_q.push_back(run_len);
         run_port = cur; run_len = 1;
      end
      if (acc) begin
         runs++;
         if (wr_sel) ref_mem[int'(a_sel[10:0])] = int'(d_sel[7:0]);
         else begin
            exp_known_q.push_back(ref_mem[int'(a_sel[10:0])] >= 0);
            exp_q.push_back(W'(ref_mem[int'(a_sel[10:0])] & 255));
            exp_port_q.push_back(own);
         end
      end
      if (own < 0) begin
         if (r0 && r1)  own = (last == 1) ? 0 : 1;
         else if (r0)   own = 0;
         else if (r1)   own = 1;
      end else begin
         mine  = (own == 0) ? r0 : r1;
         other = (own == 0) ? r1 : r0;
         if (!mine || (other && runs >= MB)) begin
            last = own; runs = 0;
            own  = other ? 1 - own : -1;
         end
      end
      @(posedge clock); #1;
      cyc++;
   endtask

   task automatic idle_step();
      step(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   // Called at posedge+k; asserts reset now, checks outputs at once, releases mid-cycle.
   task automatic do_reset(input string tag);
      nrst = 1'b0;
      #1;
      check({tag, "_gnt0"}, gnt0, 1'b0);
      check({tag, "_gnt1"}, gnt1, 1'b0);
      check({tag, "_rvalid0"}, rvalid0, 1'b0);
      check({tag, "_rvalid1"}, rvalid1, 1'b0);
      check({tag, "_rdata"}, rdata, '0);
      check({tag, "_wr_en"}, mem_wr_en, 1'b0);
      model_reset();
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
      @(posedge clock); @(posedge clock); #4;
      nrst = 1'b1;
      check({tag, "_state"}, dbg_state, ARB_IDLE);
      @(posedge clock); #1;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0;
      run_port = -1; run_len = 0;
      for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = -1;
      model_reset();
      nrst = 1'b1;
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset asserted at 5ns for 20ns, released between clock edges.
      #5 nrst = 1'b0;
      #1;
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);
      check("rst_rvalid0", rvalid0, 1'b0);
      check("rst_rvalid1", rvalid1, 1'b0);
      check("rst_wr_en", mem_wr_en, 1'b0);
      #19 nrst = 1'b1;
      @(posedge clock); #1;
      idle_step();

      // Single write then read on port 0.
      step(1, 1, 16'd65, 16'h00A5, 0, 0, '0, '0);
      check("t2_gnt_latency", obs_gnt0, 1'b0);
      step(1, 1, 16'd65, 16'h00A5, 0, 0, '0, '0);
      check("t2_gnt0", obs_gnt0, 1'b1);
      step(1, 0, 16'd65, '0, 0, 0, '0, '0);
      idle_step();
      check("t2_rvalid0", obs_rvalid0, 1'b1);
      check("t2_rdata", obs_rdata, 16'h00A5);
      idle_step();

      // Simultaneous requests from reset: port 0 first, port 1 right after req0 drops.
      do_reset("t3");
      step(1, 0, 16'd1, '0, 1, 0, 16'd2, '0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 16'd1, '0, 1, 0, 16'd2, '0);
         check("t3_gnt0", obs_gnt0, 1'b1);
      end
      step(0, 0, 16'd1, '0, 1, 0, 16'd2, '0);
      step(0, 0, 16'd1, '0, 1, 0, 16'd2, '0);
      check("t3_gnt1_no_gap", obs_gnt1, 1'b1);
      idle_step();

      // Continuous contention: 8-cycle alternating bursts; read on the last
      // port-0 burst cycle returns to port 0 in the first port-1 cycle.
      do_reset("t4");
      run_q.delete(); run_port = -1; run_len = 0;
      begin
         logic prev_gnt0;
         prev_gnt0 = 1'b0;
         for (int i = 0; i < 45; i++) begin
            step(1, 0, W'(8 + i), '0, 1, 0, W'(100 + i), '0);
            if (obs_gnt1 && prev_gnt0) begin
               check("t5_rvalid0", obs_rvalid0, 1'b1);
               check("t5_rvalid1", obs_rvalid1, 1'b0);
            end
            prev_gnt0 = obs_gnt0;
         end
      end
      check("t4_run_count", W'(run_q.size() >= 4), W'(1));
      for (int i = 0; i < run_q.size(); i++) check("t4_run_len", W'(run_q[i]), W'(MB));
      idle_step();

      // Reset mid-burst with a read in flight, then port 0 must win the tie.
      do_reset("t6pre");
      step(1, 0, 16'd5, '0, 1, 0, 16'd6, '0);
      step(1, 0, 16'd5, '0, 1, 0, 16'd6, '0);
      step(1, 0, 16'd5, '0, 1, 0, 16'd6, '0);
      check("t6_pending", rvalid0, 1'b1);
      #2;
      do_reset("t6");
      step(1, 0, 16'd5, '0, 1, 0, 16'd6, '0);
      step(1, 0, 16'd5, '0, 1, 0, 16'd6, '0);
      check("t6_port0_wins", obs_gnt0, 1'b1);
      idle_step();

      // Random traffic with sticky requests.
      begin
         bit r0, r1;
         r0 = 0; r1 = 0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) r0 = ~r0;
            if ($urandom_range(0, 4) == 0) r1 = ~r1;
            step(r0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 63)), W'($urandom),
                 r1, 1'($urandom_range(0, 1)), W'($urandom_range(0, 63)), W'($urandom));
         end
      end
      idle_step();
      idle_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
